// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction fetch cache with 128-bit lines. Hits respond after
// one cycle; misses refill from fixed-latency instruction memory.
module instr_fetch_cache #(
  parameter int LINES       = 8,
  parameter int MEM_LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  pc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  instr,
  input  logic         flush,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_dataline,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 28 - IDX;
  localparam int CW  = $clog2(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

  state_t            state, state_nxt;
  logic [31:2]       pc_q;
  logic [CW-1:0]     cnt;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_arr  [LINES];
  logic [127:0]      data_arr [LINES];

  logic [IDX-1:0]    idx_in, idx_q;
  logic [TW-1:0]     tag_in, tag_q;
  logic              hit, accept, install;
  logic              unused_pc;

  assign idx_in    = pc[4 +: IDX];
  assign tag_in    = pc[31 -: TW];
  assign idx_q     = pc_q[4 +: IDX];
  assign tag_q     = pc_q[31 -: TW];
  assign unused_pc = ^pc[1:0];

  // Lookup uses the valid bits before any same-edge flush takes effect.
  assign hit     = valid[idx_in] && (tag_arr[idx_in] == tag_in);
  assign accept  = (state == IDLE) && req_valid;
  assign install = (state == REFILL) && (cnt == CNT_LAST);

  function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = line[31:0];
      2'd1:    r = line[63:32];
      2'd2:    r = line[95:64];
      default: r = line[127:96];
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = hit ? RESPOND : REFILL;
      REFILL:  if (cnt == CNT_LAST) state_nxt = RESPOND;
      RESPOND: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESPOND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      mem_addr   <= '0;
      instr      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      valid      <= '0;
    end else begin
      if (accept) begin
        if (hit) begin
          instr     <= sel_word(data_arr[idx_in], pc[3:2]);
          hit_count <= sat_inc(hit_count);
        end else begin
          mem_addr   <= {pc[31:4], 4'h0};
          cnt        <= '0;
          miss_count <= sat_inc(miss_count);
        end
      end
      if ((state == REFILL) && !install) cnt <= cnt + 1'b1;
      if (flush) valid <= '0;
      // Install is ordered after the flush clear so the refilled line survives it.
      if (install) begin
        valid[idx_q] <= 1'b1;
        instr        <= sel_word(mem_dataline, pc_q[3:2]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pc_q <= pc[31:2];
    if (install) begin
      data_arr[idx_q] <= mem_dataline;
      tag_arr[idx_q]  <= tag_q;
    end
  end
endmodule

// File: doc/instr_fetch_cache.md
# instr_fetch_cache

Fetch-side controller that sits between the CPU's PC/fetch stage and the 128-bit-line instruction memory. It holds a small direct-mapped cache of 128-bit lines and serves hits in one cycle. On a miss it drives the line address to instruction memory, waits out the memory's fixed fetch latency, installs the line and returns the addressed 32-bit word. It also keeps hit and miss counters for performance bring-up.

## Interface
- LINES, 8: number of cache lines; a power of two ≥ 2. IDX = log2(LINES).
- MEM_LATENCY, 6: clock edges from a `mem_addr` change to the edge that samples `mem_dataline`; must be ≥ 6.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  controller accepts a request; high only in IDLE.
- pc  input  32  fetch byte address; sampled on the accept edge; pc[1:0] ignored.
- rsp_valid  output  1  `instr` is valid.
- rsp_ready  input  1  consumer accepts the response.
- instr  output  32  fetched instruction.
- flush  input  1  invalidate all lines.
- mem_addr  output  32  line address to instruction memory, always 16-byte aligned.
- mem_dataline  input  128  line from memory; byte k = bits [8k+7:8k].
- hit_count  output  16  saturating count of accepted hits.
- miss_count  output  16  saturating count of accepted misses.

## Operation
- Address split: word select = pc[3:2], index = pc[4+IDX-1:4], tag = pc[31:4+IDX].
- Storage: one data array of LINES×128 bits, plus one tag array and one valid bit per line.
- Word select: `instr` = line[32*w+31 : 32*w], where w = pc[3:2]. This gives little-endian byte order.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch pc.
  - Hit (valid[index] and tag match, checked combinationally against the incoming pc): load `instr`, increment hit_count, go to RESPOND.
  - Miss: set mem_addr ← {pc[31:4], 4'b0}, set wait counter cnt ← 0, increment miss_count, go to REFILL.
- REFILL:
  - If cnt ≠ MEM_LATENCY−1: cnt increments each cycle.
  - If cnt = MEM_LATENCY−1: write mem_dataline into data[index], write the tag, set valid[index], load `instr` from the sampled line, go to RESPOND.
- RESPOND:
  - rsp_valid = 1.
  - `instr` is held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- Back-to-back requests: no request is accepted on the same edge that a response is consumed. The minimum request-to-request spacing is 2 cycles on hits.
- mem_addr holds its last value outside REFILL; it never changes except on a miss accept.
- Refilling a line whose address equals the current mem_addr is correct. Instruction memory reloads its dataline at least every 5 cycles, so MEM_LATENCY ≥ 6 always covers a fresh load.
- flush:
  - Clears every valid bit on the next edge, in any state.
  - A refill in progress is not aborted. On the install edge, if flush is high on that same edge, the refilled line ends valid (the install wins over the flush).
  - flush in IDLE together with req_valid: the lookup uses the pre-flush valid bits.
- Counters saturate at 0xFFFF; they are never cleared except by reset.

## Timing
- Reset values: state IDLE; rsp_valid 0; req_ready 1; instr 0; mem_addr 0; hit_count 0; miss_count 0; cnt 0; all valid bits 0. Tag and data arrays need no reset.
- Reset asserted mid-REFILL or mid-RESPOND: immediately go to IDLE and drop rsp_valid; the line is not installed.
- Hit latency: request accepted on edge E0 → rsp_valid high after E0 (1 cycle).
- Miss latency:
  - mem_addr updates at the accept edge E0.
  - mem_dataline is sampled at E0+MEM_LATENCY.
  - rsp_valid goes high after E0+MEM_LATENCY (6 cycles at default).
- rsp_valid and instr do not change while rsp_valid & !rsp_ready.

## Test plan
- Reset, then request pc=0x00 → miss: mem_addr=0x00 after accept; rsp_valid 6 cycles later with instr=0x00430800; miss_count=1.
- Then request pc=0x04 → hit: rsp_valid 1 cycle after accept with instr=0x00A62001; mem_addr unchanged; hit_count=1.
- Request pc=0x30 and then pc=0x2C → two misses (index 3, then index 2): instr=0x1800FFF3, then 0x12720004; miss_count=3.
- Conflict: request pc=0x80 (index 0, new tag) → miss with mem_addr=0x80; then request pc=0x00 → miss again, instr=0x00430800.
- Backpressure and flush: hold rsp_ready=0 for 3 cycles on a response → instr and rsp_valid stable, req_ready=0. Then pulse flush; request pc=0x04 → miss with instr=0x00A62001.
- Drop rst_n in cycle 3 of a REFILL → rsp_valid=0 asynchronously and all counters 0. After release, request pc=0x00 → miss, full 6-cycle latency.
